// File: rtl/dmem_subsystem_if.sv
// Controller-to-data-memory bus: word request from the controller, registered read data back.
interface dmem_subsystem_if;
  logic        dmem_en;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;

  modport master (output dmem_en, dmem_we, dmem_addr, dmem_wdata, input dmem_rdata);
  modport slave  (input dmem_en, dmem_we, dmem_addr, dmem_wdata, output dmem_rdata);
endinterface

// File: rtl/dmem_subsystem.sv
// Data-side memory stage: word RAM, address decoder, GPIO and a compare timer.
// Reads return one cycle after the request edge; unmapped accesses pulse bus_err.
module dmem_subsystem #(
  parameter int unsigned RAM_WORDS = 1024,
  parameter int unsigned GPIO_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  dmem_subsystem_if.slave   bus,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq,
  output logic              bus_err
);
  localparam int unsigned AW = $clog2(RAM_WORDS);

  typedef enum logic [2:0] {
    REG_NONE, REG_RAM, REG_GPIO_OUT, REG_GPIO_IN,
    REG_TMR_CNT, REG_TMR_CMP, REG_TMR_CTRL, REG_TMR_STAT
  } region_e;

  logic [31:0]       mem_q [RAM_WORDS];
  logic [31:0]       rdata_q, rdata_d;
  logic              bus_err_q, bus_err_d;
  logic [GPIO_W-1:0] gpio_q, gpio_d;
  logic [GPIO_W-1:0] sync1_q, sync2_q;
  logic [31:0]       cnt_q, cnt_d;
  logic [31:0]       cmp_q, cmp_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic              flag_q, flag_d;
  logic              irq_q, irq_d;

  region_e           region_s;
  logic              wr_s, rd_s, match_s;
  logic [AW-1:0]     ram_idx_s;
  logic [31:0]       rd_val_s;
  logic [1:0]        addr_unused_s;

  assign wr_s          = bus.dmem_en & bus.dmem_we;
  assign rd_s          = bus.dmem_en & ~bus.dmem_we;
  assign ram_idx_s     = bus.dmem_addr[AW+1:2];
  assign addr_unused_s = bus.dmem_addr[1:0];
  assign match_s       = ctrl_q[0] & (cnt_q == cmp_q);

  // Address decode on the word address; byte offset bits never participate.
  always_comb begin
    region_s = REG_NONE;
    if (bus.dmem_addr[31:AW+2] == {(30-AW){1'b0}}) begin
      region_s = REG_RAM;
    end else begin
      case (bus.dmem_addr[31:2])
        30'h3FFF_C000: region_s = REG_GPIO_OUT;
        30'h3FFF_C001: region_s = REG_GPIO_IN;
        30'h3FFF_C002: region_s = REG_TMR_CNT;
        30'h3FFF_C003: region_s = REG_TMR_CMP;
        30'h3FFF_C004: region_s = REG_TMR_CTRL;
        30'h3FFF_C005: region_s = REG_TMR_STAT;
        default:       region_s = REG_NONE;
      endcase
    end
  end

  // Read mux sees pre-edge state, which gives read-before-write on registers.
  always_comb begin
    rd_val_s = 32'h0000_0000;
    case (region_s)
      REG_RAM:      rd_val_s = mem_q[ram_idx_s];
      REG_GPIO_OUT: rd_val_s = 32'(gpio_q);
      REG_GPIO_IN:  rd_val_s = 32'(sync2_q);
      REG_TMR_CNT:  rd_val_s = cnt_q;
      REG_TMR_CMP:  rd_val_s = cmp_q;
      REG_TMR_CTRL: rd_val_s = {29'h0000_0000, ctrl_q};
      REG_TMR_STAT: rd_val_s = {31'h0000_0000, flag_q};
      default:      rd_val_s = 32'h0000_0000;
    endcase
  end

  // Next-state for bus response, GPIO and timer; software writes override hardware counting.
  always_comb begin
    rdata_d   = rdata_q;
    bus_err_d = 1'b0;
    gpio_d    = gpio_q;
    cnt_d     = cnt_q;
    cmp_d     = cmp_q;
    ctrl_d    = ctrl_q;
    flag_d    = flag_q;
    irq_d     = flag_q & ctrl_q[2];

    if (rd_s) begin
      rdata_d = rd_val_s;
    end else begin
      rdata_d = rdata_q;
    end

    if (bus.dmem_en && (region_s == REG_NONE)) begin
      bus_err_d = 1'b1;
    end else begin
      bus_err_d = 1'b0;
    end

    if (ctrl_q[0]) begin
      if (match_s && ctrl_q[1]) begin
        cnt_d = 32'h0000_0000;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end else begin
      cnt_d = cnt_q;
    end

    if (wr_s) begin
      case (region_s)
        REG_GPIO_OUT: gpio_d = bus.dmem_wdata[GPIO_W-1:0];
        REG_TMR_CNT:  cnt_d  = bus.dmem_wdata;
        REG_TMR_CMP:  cmp_d  = bus.dmem_wdata;
        REG_TMR_CTRL: ctrl_d = bus.dmem_wdata[2:0];
        REG_TMR_STAT: flag_d = bus.dmem_wdata[0] ? 1'b0 : flag_q;
        default:      gpio_d = gpio_q;
      endcase
    end else begin
      gpio_d = gpio_q;
    end

    // A hardware match beats a same-cycle clear.
    if (match_s) begin
      flag_d = 1'b1;
    end else begin
      flag_d = flag_d;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q   <= 32'h0000_0000;
      bus_err_q <= 1'b0;
      gpio_q    <= {GPIO_W{1'b0}};
      sync1_q   <= {GPIO_W{1'b0}};
      sync2_q   <= {GPIO_W{1'b0}};
      cnt_q     <= 32'h0000_0000;
      cmp_q     <= 32'h0000_0000;
      ctrl_q    <= 3'b000;
      flag_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
      gpio_q    <= gpio_d;
      sync1_q   <= gpio_in;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      cmp_q     <= cmp_d;
      ctrl_q    <= ctrl_d;
      flag_q    <= flag_d;
      irq_q     <= irq_d;
    end
  end

  // RAM array is not reset; a write coincident with reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && wr_s && (region_s == REG_RAM)) begin
      mem_q[ram_idx_s] <= bus.dmem_wdata;
    end
  end

  assign bus.dmem_rdata = rdata_q;
  assign gpio_out       = gpio_q;
  assign timer_irq      = irq_q;
  assign bus_err        = bus_err_q;
endmodule

// File: tb/tb_dmem_subsystem.sv
// Bench for dmem_subsystem: directed scenarios with literal expectations plus
// randomized traffic, all outputs compared every cycle against a behavioural model.
module tb_dmem_subsystem;
  localparam int RAM_WORDS = 1024;
  localparam int GPIO_W    = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [GPIO_W-1:0] gpio_in;
  logic [GPIO_W-1:0] gpio_out;
  logic              timer_irq;
  logic              bus_err;

  dmem_subsystem_if bus();

  dmem_subsystem #(.RAM_WORDS(RAM_WORDS), .GPIO_W(GPIO_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .timer_irq (timer_irq),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_on = 1'b0;

  // Behavioural model state
  logic [31:0]       m_ram [RAM_WORDS];
  logic [31:0]       m_rdata, m_cnt, m_cmp;
  logic [2:0]        m_ctrl;
  logic              m_flag, m_irq, m_berr;
  logic [GPIO_W-1:0] m_gpio, m_s1, m_s2;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Advance the model by one clock edge given the inputs seen at that edge.
  function automatic void model_step(input bit r, input bit en, input bit we,
                                     input logic [31:0] a, input logic [31:0] wd,
                                     input logic [GPIO_W-1:0] pin);
    logic [31:0] w;
    logic [31:0] rv;
    logic [31:0] ncnt, ncmp;
    logic [2:0]  nctrl;
    logic [GPIO_W-1:0] ngpio;
    bit hit, mt, nflag, nirq;
    if (r) begin
      m_rdata = 32'h0; m_cnt = 32'h0; m_cmp = 32'h0; m_ctrl = 3'h0;
      m_flag = 1'b0; m_irq = 1'b0; m_berr = 1'b0;
      m_gpio = '0; m_s1 = '0; m_s2 = '0;
      return;
    end
    w   = {a[31:2], 2'b00};
    hit = 1'b1;
    rv  = 32'h0;
    if (w < RAM_WORDS * 4) rv = m_ram[w[11:2]];
    else begin
      case (w)
        32'hFFFF_0000: rv = 32'(m_gpio);
        32'hFFFF_0004: rv = 32'(m_s2);
        32'hFFFF_0008: rv = m_cnt;
        32'hFFFF_000C: rv = m_cmp;
        32'hFFFF_0010: rv = 32'(m_ctrl);
        32'hFFFF_0014: rv = 32'(m_flag);
        default:       hit = 1'b0;
      endcase
    end
    nirq  = m_flag & m_ctrl[2];
    mt    = m_ctrl[0] && (m_cnt == m_cmp);
    if (!m_ctrl[0])           ncnt = m_cnt;
    else if (mt && m_ctrl[1]) ncnt = 32'h0;
    else                      ncnt = m_cnt + 32'd1;
    ncmp  = m_cmp;
    nctrl = m_ctrl;
    ngpio = m_gpio;
    nflag = m_flag;
    if (en && we) begin
      if (w < RAM_WORDS * 4) m_ram[w[11:2]] = wd;
      else begin
        case (w)
          32'hFFFF_0000: ngpio = wd[GPIO_W-1:0];
          32'hFFFF_0008: ncnt  = wd;
          32'hFFFF_000C: ncmp  = wd;
          32'hFFFF_0010: nctrl = wd[2:0];
          32'hFFFF_0014: if (wd[0]) nflag = 1'b0;
          default: ;
        endcase
      end
    end
    if (mt) nflag = 1'b1;
    if (en && !we) m_rdata = rv;
    m_berr = en && !hit;
    m_cnt = ncnt; m_cmp = ncmp; m_ctrl = nctrl; m_gpio = ngpio;
    m_flag = nflag; m_irq = nirq;
    m_s2 = m_s1; m_s1 = pin;
  endfunction

  task automatic cyc(input bit r, input bit en, input bit we,
                     input logic [31:0] a, input logic [31:0] wd);
    rst            = r;
    bus.dmem_en    = en;
    bus.dmem_we    = we;
    bus.dmem_addr  = a;
    bus.dmem_wdata = wd;
    @(posedge clk);
    model_step(r, en, we, a, wd, gpio_in);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b0, 1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    cyc(1'b0, 1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_on) begin
      chk("rdata",     bus.dmem_rdata, m_rdata);
      chk("gpio_out",  32'(gpio_out),  32'(m_gpio));
      chk("timer_irq", 32'(timer_irq), 32'(m_irq));
      chk("bus_err",   32'(bus_err),   32'(m_berr));
    end
  end

  initial begin
    logic [31:0] seq_reload [5];
    logic [31:0] seq_wrap [9];
    logic [31:0] unm [5];
    seq_reload = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
    seq_wrap   = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd2,
                   32'd3, 32'd4, 32'd5, 32'd6};
    unm        = '{32'h0000_1000, 32'hFFFF_0018, 32'h8000_0000,
                   32'hFFFF_FFFC, 32'h7FFF_0000};
    gpio_in = '0;
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check_on = 1'b1;
    chk("reset_rdata", bus.dmem_rdata, 32'h0);
    chk("reset_gpio",  32'(gpio_out),  32'h0);
    chk("reset_irq",   32'(timer_irq), 32'h0);
    chk("reset_berr",  32'(bus_err),   32'h0);

    for (int k = 0; k < 16; k++) begin
      wr(32'(k * 4), $urandom);
      wr(32'((1008 + k) * 4), $urandom);
    end

    // RAM round trip, hold on idle and write, byte offset ignored
    wr(32'h10, 32'hDEAD_BEEF);
    rd(32'h10);
    chk("ram_rt", bus.dmem_rdata, 32'hDEAD_BEEF);
    idle();
    chk("ram_hold_idle", bus.dmem_rdata, 32'hDEAD_BEEF);
    rd(32'h13);
    chk("ram_byteoff", bus.dmem_rdata, 32'hDEAD_BEEF);
    wr(32'h20, 32'h1);
    chk("ram_hold_wr", bus.dmem_rdata, 32'hDEAD_BEEF);
    rd(32'h20);
    chk("ram_rd2", bus.dmem_rdata, 32'h1);
    wr(32'hFFC, 32'h1234_5678);
    rd(32'hFFC);
    chk("ram_top", bus.dmem_rdata, 32'h1234_5678);

    // GPIO
    wr(32'hFFFF_0000, 32'h1A5);
    chk("gpio_out", 32'(gpio_out), 32'hA5);
    gpio_in = 8'h3C;
    idle();
    idle();
    rd(32'hFFFF_0004);
    chk("gpio_in", bus.dmem_rdata, 32'h3C);

    // Timer auto-reload
    wr(32'hFFFF_000C, 32'd3);
    wr(32'hFFFF_0008, 32'd0);
    wr(32'hFFFF_0010, 32'h7);
    for (int k = 0; k < 5; k++) begin
      rd(32'hFFFF_0008);
      chk("reload_cnt", bus.dmem_rdata, seq_reload[k]);
      if (k == 3) chk("irq_lag", 32'(timer_irq), 32'h0);
    end
    chk("irq_set", 32'(timer_irq), 32'h1);
    wr(32'hFFFF_0014, 32'h1);
    idle();
    chk("irq_clr", 32'(timer_irq), 32'h0);
    wr(32'hFFFF_0014, 32'h1);
    rd(32'hFFFF_0014);
    chk("set_wins", bus.dmem_rdata, 32'h1);
    chk("irq_again", 32'(timer_irq), 32'h1);

    // Timer without reload, across the 32-bit wrap
    wr(32'hFFFF_0010, 32'h0);
    wr(32'hFFFF_0014, 32'h1);
    wr(32'hFFFF_000C, 32'd5);
    wr(32'hFFFF_0008, 32'hFFFF_FFFE);
    wr(32'hFFFF_0010, 32'h1);
    for (int k = 0; k < 9; k++) begin
      rd(32'hFFFF_0008);
      chk("wrap_cnt", bus.dmem_rdata, seq_wrap[k]);
    end
    wr(32'hFFFF_0008, 32'd100);
    rd(32'hFFFF_0008);
    chk("sw_cnt_wins", bus.dmem_rdata, 32'd100);
    rd(32'hFFFF_0014);
    chk("wrap_flag", bus.dmem_rdata, 32'h1);
    chk("irq_masked", 32'(timer_irq), 32'h0);
    wr(32'hFFFF_0010, 32'h0);

    // Unmapped and read-only
    rd(32'h8000_0000);
    chk("unm_rdata", bus.dmem_rdata, 32'h0);
    chk("unm_berr", 32'(bus_err), 32'h1);
    idle();
    chk("berr_pulse", 32'(bus_err), 32'h0);
    rd(32'hFFC);
    rd(32'h1000);
    chk("ram_edge_unm", bus.dmem_rdata, 32'h0);
    chk("ram_edge_berr", 32'(bus_err), 32'h1);
    wr(32'hFFFF_0004, 32'hFF);
    chk("ro_no_berr", 32'(bus_err), 32'h0);
    rd(32'hFFFF_0004);
    chk("ro_ignored", bus.dmem_rdata, 32'h3C);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      bit r, en, we;
      int kind, word;
      logic [31:0] a, wd;
      r    = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 7) == 0) gpio_in = GPIO_W'($urandom);
      kind = $urandom_range(0, 9);
      en   = (kind != 9);
      we   = $urandom_range(0, 1) == 1;
      wd   = $urandom;
      if (kind <= 3) begin
        word = $urandom_range(0, 31);
        a    = 32'(((word < 16) ? word : 992 + word) * 4 + $urandom_range(0, 3));
      end else if (kind <= 7) begin
        a  = 32'hFFFF_0000 + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) wd = 32'($urandom_range(0, 15));
      end else begin
        a = unm[$urandom_range(0, 4)];
      end
      cyc(r, en, we, a, wd);
    end

    // Reset during a read, and write coincident with reset
    wr(32'h8, 32'hCAFE_F00D);
    wr(32'hFFFF_0000, 32'hFF);
    wr(32'hFFFF_0008, 32'd55);
    wr(32'hFFFF_0010, 32'h5);
    rd(32'h8);
    chk("pre_rst_rd", bus.dmem_rdata, 32'hCAFE_F00D);
    cyc(1'b1, 1'b1, 1'b0, 32'h8, 32'h0);
    chk("rst_rdata", bus.dmem_rdata, 32'h0);
    chk("rst_gpio", 32'(gpio_out), 32'h0);
    cyc(1'b1, 1'b1, 1'b1, 32'h8, 32'h1111_1111);
    rd(32'hFFFF_0008);
    chk("rst_cnt", bus.dmem_rdata, 32'h0);
    rd(32'hFFFF_0010);
    chk("rst_ctrl", bus.dmem_rdata, 32'h0);
    rd(32'h8);
    chk("rst_wr_ignored", bus.dmem_rdata, 32'hCAFE_F00D);
    idle();

    check_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
